// File: rtl/fetch_pkg.sv
// Shared types and constants for the queued fetch stage.
package fetch_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned PC_INC       = 4;

  // One fetch-queue entry: instruction word plus its PC and PC+4.
  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] instr;
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised synchronous FIFO with flush; the head entry is read straight
// from registered storage, so there is no write-to-read bypass.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0],
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  T                 i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output T                 o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Flush wins over push/pop; pop on empty and push on full-without-pop are ignored.
  assign w_pop  = i_pop && !i_flush && !o_empty;
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  // Storage array; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_stage_q.sv
// Queued IF stage: credit-limited PC-ordered requests to a variable-latency
// instruction memory, in-order responses buffered in a fetch queue, decode
// handshake, and redirect with discard of stale in-flight responses.
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter int unsigned     CNT_W    = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pctare,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] instrd,
  output logic [XLEN-1:0] pcd,
  output logic [XLEN-1:0] pcplus4D
);

  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_inflight;
  logic [CNT_W-1:0] w_q_count;
  logic [CNT_W:0]   w_credit_used;
  logic             w_tag_empty;
  logic             w_tag_full;
  logic             w_q_empty;
  logic             w_q_full;
  logic [XLEN-1:0]  w_tag_head;
  logic             w_req_fire;
  logic             w_rsp_keep;
  logic             w_q_pop;
  fetch_entry_t     w_q_in;
  fetch_entry_t     w_q_head;

  // In-flight count is the PC-tag FIFO occupancy: one tag per outstanding request.
  assign w_credit_used  = {1'b0, w_inflight} + {1'b0, w_q_count};
  assign imem_req_valid = rst && !pcsrc && (w_credit_used < (CNT_W+1)'(FQ_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_keep = imem_rsp_valid && (r_drop == '0) && !pcsrc;
  assign dec_valid  = !w_q_empty;
  assign w_q_pop    = dec_valid && dec_ready;

  // Queue entry assembled from the response and the tag of its request.
  always_comb begin
    w_q_in         = '0;
    w_q_in.instr   = imem_rsp_data;
    w_q_in.pc      = w_tag_head;
    w_q_in.pcplus4 = w_tag_head + XLEN'(PC_INC);
  end

  // Decode outputs are forced to zero while no instruction is presented.
  always_comb begin
    instrd   = '0;
    pcd      = '0;
    pcplus4D = '0;
    if (dec_valid) begin
      instrd   = w_q_head.instr;
      pcd      = w_q_head.pc;
      pcplus4D = w_q_head.pcplus4;
    end
  end

  // Fetch PC: redirect target or sequential advance on accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_pc <= RESET_PC;
    else if (pcsrc)      r_pc <= pctare;
    else if (w_req_fire) r_pc <= r_pc + XLEN'(PC_INC);
  end

  // Stale-response counter: on redirect, everything still outstanding after
  // this cycle's response must be thrown away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_drop <= '0;
    else if (pcsrc)                            r_drop <= w_inflight - CNT_W'(imem_rsp_valid);
    else if (imem_rsp_valid && r_drop != '0)   r_drop <= r_drop - 1'b1;
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (logic [XLEN-1:0]),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (imem_rsp_valid),
    .i_flush (1'b0),
    .o_head  (w_tag_head),
    .o_count (w_inflight),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full)
  );

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (fetch_entry_t),
    .CNT_W (CNT_W)
  ) u_fetch_q (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_rsp_keep),
    .i_data  (w_q_in),
    .i_pop   (w_q_pop),
    .i_flush (pcsrc),
    .o_head  (w_q_head),
    .o_count (w_q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> !w_tag_empty);
  a_tag_no_ovf: assert property (@(posedge clk) disable iff (!rst)
    w_req_fire |-> !w_tag_full);
  a_q_no_ovf: assert property (@(posedge clk) disable iff (!rst)
    w_rsp_keep |-> (!w_q_full || w_q_pop));

endmodule

// File: tb/tb_fetch_stage_q.sv
// Bench for fetch_stage_q: queue-level reference model plus directed and
// random phases, and a second instance with a near-wrap reset PC.
module tb_fetch_stage_q;

  localparam int unsigned D     = 4;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        pcsrc;
  logic [31:0] pctare;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        dec_ready;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        dec_valid;
  logic [31:0] instrd, pcd, pcplus4d;

  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_req_valid;
  logic [31:0] b_req_addr;
  logic        b_dec_valid;
  logic [31:0] b_instrd, b_pcd, b_pcplus4d;

  fetch_stage_q #(.XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .pctare(pctare),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instrd(instrd), .pcd(pcd), .pcplus4D(pcplus4d)
  );

  fetch_stage_q #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(D)) u_dut_wrap (
    .clk(clk), .rst(rst), .pcsrc(1'b0), .pctare(32'h0),
    .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .dec_valid(b_dec_valid), .dec_ready(1'b1),
    .instrd(b_instrd), .pcd(b_pcd), .pcplus4D(b_pcplus4d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } qent_t;
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  typedef struct {
    bit reqv; logic [31:0] addr; bit acc; bit decv; bit deq;
    logic [31:0] pcd; logic [31:0] instr; logic [31:0] p4;
  } hist_t;
  typedef struct { logic [31:0] instr; logic [31:0] pcd; logic [31:0] p4; } bdec_t;

  infl_t       m_infl[$];
  qent_t       m_q[$];
  mreq_t       mem_q[$];
  hist_t       hist[$];
  logic [31:0] m_pc;
  logic [31:0] dq_pc[$];
  logic [31:0] dq_in[$];
  logic [31:0] b_acc[$];
  bdec_t       b_dec[$];
  bit          b_fire_prev;
  logic [31:0] b_addr_prev;
  int unsigned cyc;
  int unsigned lat;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at the falling edge: drive memory
  // responses, compare DUT outputs with the model, advance the model.
  task automatic cycle();
    bit          exp_reqv, exp_decv, fire;
    logic [31:0] e_in, e_pc, e_p4;
    infl_t       f;
    hist_t       h;
    if (!rst) begin
      mem_q.delete();
      rsp_valid   = 1'b0;
      rsp_data    = '0;
      b_rsp_valid = 1'b0;
      b_rsp_data  = '0;
    end else begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_q[0].addr ^ MAGIC;
        void'(mem_q.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
      end
      b_rsp_valid = b_fire_prev;
      b_rsp_data  = b_addr_prev ^ MAGIC;
    end
    #2;
    if (!rst) begin
      m_infl.delete();
      m_q.delete();
      m_pc = 32'h0;
    end
    exp_reqv = rst && !pcsrc && (m_infl.size() + m_q.size() < D);
    exp_decv = rst && (m_q.size() > 0);
    e_in = '0; e_pc = '0; e_p4 = '0;
    if (exp_decv) begin
      e_in = m_q[0].instr;
      e_pc = m_q[0].pc;
      e_p4 = m_q[0].pc + 32'd4;
    end
    chk("req_valid", {31'b0, req_valid}, {31'b0, exp_reqv});
    chk("req_addr", req_addr, m_pc);
    chk("dec_valid", {31'b0, dec_valid}, {31'b0, exp_decv});
    chk("instrd", instrd, e_in);
    chk("pcd", pcd, e_pc);
    chk("pcplus4D", pcplus4d, e_p4);
    if (rst) begin
      h.reqv = req_valid; h.addr = req_addr; h.acc = req_valid && req_ready;
      h.decv = dec_valid; h.deq = dec_valid && dec_ready && !pcsrc;
      h.pcd = pcd; h.instr = instrd; h.p4 = pcplus4d;
      hist.push_back(h);
      if (b_req_valid && b_acc.size() < 3) b_acc.push_back(b_req_addr);
      if (b_dec_valid && b_dec.size() < 3) b_dec.push_back('{b_instrd, b_pcd, b_pcplus4d});
      fire = exp_reqv && req_ready;
      if (exp_decv && dec_ready && !pcsrc) void'(m_q.pop_front());
      if (rsp_valid && m_infl.size() > 0) begin
        f = m_infl.pop_front();
        if (!f.stale && !pcsrc) m_q.push_back('{rsp_data, f.pc});
      end
      if (fire) begin
        m_infl.push_back('{m_pc, 1'b0});
        mem_q.push_back('{m_pc, cyc + lat});
        m_pc = m_pc + 32'd4;
      end
      if (pcsrc) begin
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_q.delete();
        m_pc = pctare;
      end
      b_fire_prev = b_req_valid;
      b_addr_prev = b_req_addr;
    end else begin
      b_fire_prev = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b0; pcsrc = 1'b0; req_ready = 1'b0; dec_ready = 1'b0;
    repeat (n) cycle();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_instrd", instrd, 32'h0);
    chk("rst_pcd", pcd, 32'h0);
    chk("rst_pcplus4D", pcplus4d, 32'h0);
    rst = 1'b1;
  endtask

  task automatic gather(input int unsigned from);
    dq_pc.delete();
    dq_in.delete();
    for (int unsigned i = from; i < hist.size(); i++)
      if (hist[i].deq) begin
        dq_pc.push_back(hist[i].pcd);
        dq_in.push_back(hist[i].instr);
      end
  endtask

  task automatic chk_dq(input string name, input int unsigned idx, input logic [31:0] exp_pc);
    if (idx < dq_pc.size()) begin
      chk(name, dq_pc[idx], exp_pc);
      chk({name, "_instr"}, dq_in[idx], exp_pc ^ MAGIC);
    end else begin
      chk({name, "_present"}, dq_pc.size(), idx + 1);
    end
  endtask

  initial begin
    int unsigned h0, h1, k, a, d, cnt;
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1;
    rst = 1'b0; pcsrc = 1'b0; pctare = '0; req_ready = 1'b0; dec_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; b_rsp_valid = 1'b0; b_rsp_data = '0;
    b_fire_prev = 1'b0; b_addr_prev = '0;
    @(negedge clk);

    // Streaming with a 1-cycle memory
    lat = 1; do_reset(3);
    req_ready = 1'b1; dec_ready = 1'b1;
    h0 = hist.size();
    repeat (12) cycle();
    a = 0; d = 0;
    for (int unsigned i = hist.size(); i > h0; i--) begin
      if (hist[i-1].acc)  a = i - 1;
      if (hist[i-1].decv) d = i - 1;
    end
    chk("first_dec_latency", d - a, 32'd2);
    gather(h0);
    chk_dq("A_dec0", 0, 32'h0);
    chk_dq("A_dec1", 1, 32'h4);
    chk_dq("A_dec2", 2, 32'h8);

    // Decode stall fills the queue, then drains in order
    lat = 1; do_reset(2);
    req_ready = 1'b1; dec_ready = 1'b0;
    h0 = hist.size();
    repeat (10) cycle();
    cnt = 0;
    for (int unsigned i = h0; i < hist.size(); i++) if (hist[i].acc) cnt++;
    chk("B_accepts", cnt, 32'd4);
    chk("B_req_stopped", {31'b0, hist[hist.size()-1].reqv}, 32'd0);
    chk("B_hold_decv", {31'b0, hist[hist.size()-1].decv}, 32'd1);
    chk("B_hold_pcd", hist[hist.size()-1].pcd, 32'h0);
    dec_ready = 1'b1;
    h1 = hist.size();
    repeat (10) cycle();
    gather(h1);
    chk_dq("B_dec0", 0, 32'h0);
    chk_dq("B_dec1", 1, 32'h4);
    chk_dq("B_dec2", 2, 32'h8);
    chk_dq("B_dec3", 3, 32'hC);
    chk_dq("B_dec4", 4, 32'h10);

    // Redirect with three stale responses outstanding
    lat = 3; do_reset(2);
    req_ready = 1'b1; dec_ready = 1'b1;
    h0 = hist.size();
    repeat (3) cycle();
    pcsrc = 1'b1; pctare = 32'h100;
    cycle();
    pcsrc = 1'b0;
    repeat (12) cycle();
    gather(h0);
    chk_dq("C_dec0", 0, 32'h100);
    chk_dq("C_dec1", 1, 32'h104);

    // Redirect coinciding with a response and a decode accept
    lat = 1; do_reset(2);
    req_ready = 1'b1; dec_ready = 1'b1;
    repeat (6) cycle();
    k = hist.size();
    pcsrc = 1'b1; pctare = 32'h40;
    cycle();
    pcsrc = 1'b0;
    repeat (4) cycle();
    chk("D_decv_after", {31'b0, hist[k+1].decv}, 32'd0);
    chk("D_next_addr", hist[k+1].addr, 32'h40);
    chk("D_next_reqv", {31'b0, hist[k+1].reqv}, 32'd1);
    gather(k + 1);
    chk_dq("D_dec0", 0, 32'h40);

    // Randomised segments with varying memory latency
    for (int seg = 0; seg < 4; seg++) begin
      lat = 1 + ($urandom % 3);
      do_reset(2);
      repeat (150) begin
        req_ready = ($urandom % 10) < 7;
        dec_ready = ($urandom % 10) < 7;
        pcsrc     = ($urandom % 100) < 6;
        pctare    = $urandom & 32'hFFFF_FFFC;
        cycle();
      end
      pcsrc = 1'b0;
    end

    // Asynchronous reset with three entries queued
    lat = 1; do_reset(2);
    req_ready = 1'b1; dec_ready = 1'b0;
    repeat (4) cycle();
    rsp_valid = 1'b0;
    #1;
    chk("F_pre_decv", {31'b0, dec_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("F_async_req_valid", {31'b0, req_valid}, 32'd0);
    chk("F_async_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("F_async_instrd", instrd, 32'h0);
    chk("F_async_pcd", pcd, 32'h0);
    chk("F_async_pcplus4D", pcplus4d, 32'h0);
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b1;
    h0 = hist.size();
    cycle();
    chk("F_first_addr", hist[h0].addr, 32'h0);
    chk("F_first_acc", {31'b0, hist[h0].acc}, 32'd1);

    // Reset-PC wrap instance, recorded during the first streaming phase
    chk("W_acc_count", b_acc.size(), 32'd3);
    chk("W_dec_count", b_dec.size(), 32'd3);
    if (b_acc.size() == 3 && b_dec.size() == 3) begin
      chk("W_addr0", b_acc[0], 32'hFFFF_FFF8);
      chk("W_addr1", b_acc[1], 32'hFFFF_FFFC);
      chk("W_addr2", b_acc[2], 32'h0000_0000);
      chk("W_instr0", b_dec[0].instr, 32'h5A5A_FFF8);
      chk("W_pcd1", b_dec[1].pcd, 32'hFFFF_FFFC);
      chk("W_pcplus4_1", b_dec[1].p4, 32'h0000_0000);
      chk("W_pcd2", b_dec[2].pcd, 32'h0000_0000);
      chk("W_pcplus4_2", b_dec[2].p4, 32'h0000_0004);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
